// File: rtl/ecg_pkg.sv
// rtl/ecg_pkg.sv - shared ECG constants and RR generator state type
//
// Purpose: common definitions for the ECG RR-interval path.
// Contents: RR_W_DEFAULT (RR value width in sample ticks), SAMPLE_HZ
// (sample tick rate), rr_gen_state_t (peak generator FSM states).
package ecg_pkg;

  localparam int RR_W_DEFAULT = 16;
  localparam int SAMPLE_HZ    = 100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rr_gen_state_t;

endpackage

// File: rtl/rr_peak_generator_if.sv
// rtl/rr_peak_generator_if.sv - RR value valid/ready handshake bundle
//
// Purpose: carries RR interval values into the peak generator.
// Signals: rr_in (RR interval in sample ticks), rr_valid (rr_in valid),
// rr_ready (receiver can accept).
// Modports: master drives rr_in/rr_valid, slave drives rr_ready.
interface rr_peak_generator_if
  import ecg_pkg::*;
#(
  parameter int RR_W = RR_W_DEFAULT
);

  logic [RR_W-1:0] rr_in;
  logic            rr_valid;
  logic            rr_ready;

  modport master (output rr_in, output rr_valid, input rr_ready);
  modport slave  (input rr_in, input rr_valid, output rr_ready);

endinterface

// File: rtl/rr_fifo.sv
// rtl/rr_fifo.sv - synchronous FIFO with wrap-bit pointers and level output
//
// Purpose: buffers RR values between the upstream handshake and the peak FSM.
// Ports: clk, rst (async active-high, flushes pointers), push/push_data,
// pop/pop_data (head word, valid while !empty), full, empty, level.
module rr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: resetting the pointers already empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rr_peak_generator.sv
// rtl/rr_peak_generator.sv - synthetic R-peak source replaying buffered RR intervals
//
// Purpose: pops RR values N from a FIFO and emits r_peak so that consecutive
// peaks are N+1 sample ticks apart; a 0-based capture-and-clear tick counter
// downstream therefore reads back exactly N.
// Ports: clk, rst (async active-high), sample_en (sample tick, one clk wide),
// rr (slave handshake: rr_in/rr_valid in, rr_ready out), r_peak (registered
// peak level, one sample period per peak), busy (state RUN), underrun (one-clk
// pulse on a peak fired with the FIFO empty), fifo_level (entries held).
module rr_peak_generator
  import ecg_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int RR_W  = RR_W_DEFAULT,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  rr_peak_generator_if.slave   rr,
  output logic                 r_peak,
  output logic                 busy,
  output logic                 underrun,
  output logic [LVL_W-1:0]     fifo_level
);

  rr_gen_state_t   state;
  rr_gen_state_t   state_n;
  logic [RR_W-1:0] cnt;
  logic [RR_W-1:0] cnt_n;
  logic [RR_W-1:0] head;
  logic            r_peak_n;
  logic            underrun_n;
  logic            pop;
  logic            push;
  logic            full;
  logic            empty;
  logic            ready_en;

  // ready_en holds rr_ready low during reset and releases it on the first
  // clk after rst deasserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  assign rr.rr_ready = ready_en && !full;
  assign push        = rr.rr_valid && rr.rr_ready;
  assign busy        = (state == RUN);

  rr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rr.rr_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      r_peak   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      r_peak   <= r_peak_n;
      underrun <= underrun_n;
    end
  end

  // Everything except the underrun pulse holds between sample ticks. The
  // empty flag reflects the registered FIFO state, so a push landing on the
  // same clk as a fire is not visible until the next tick.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    r_peak_n   = r_peak;
    underrun_n = 1'b0;
    pop        = 1'b0;
    if (sample_en) begin
      case (state)
        IDLE: begin
          r_peak_n = 1'b0;
          if (!empty) begin
            // Anchor peak: the interval to the next peak starts here.
            pop      = 1'b1;
            cnt_n    = head;
            r_peak_n = 1'b1;
            state_n  = RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt_n    = cnt - RR_W'(1);
            r_peak_n = 1'b0;
          end else begin
            // Fire; with N=0 the level simply stays high for another period.
            r_peak_n = 1'b1;
            if (!empty) begin
              pop   = 1'b1;
              cnt_n = head;
            end else begin
              underrun_n = 1'b1;
              state_n    = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_peak_generator.sv
// tb/tb_rr_peak_generator.sv - self-checking bench for rr_peak_generator
module tb_rr_peak_generator;

  localparam int DEPTH = 4;
  localparam int RR_W  = 16;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  logic             r_peak;
  logic             busy;
  logic             underrun;
  logic [LVL_W-1:0] fifo_level;

  rr_peak_generator_if #(.RR_W(RR_W)) rr_bus ();

  rr_peak_generator #(
    .DEPTH (DEPTH),
    .RR_W  (RR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .rr         (rr_bus.slave),
    .r_peak     (r_peak),
    .busy       (busy),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Behavioural model: a queue of pending intervals and the absolute tick
  // number at which the next peak is due.
  int mq[$];
  bit m_active, m_peak, m_underrun, m_ready_en;
  int m_tick, m_next;

  // Downstream receiver and observation traces.
  int rx_cnt;
  bit prev_rp, prev_busy;
  int caps[$];
  int peak_cyc[$];
  bit rp_hist[$];
  int peak_cnt, ur_peak_idx, ur_cyc, busy_fall_cyc, cyc;
  bit ur_seen;

  always @(posedge clk) begin : chk
    bit rdy_pre;
    int n;
    #1;
    cyc++;
    if (rst) begin
      mq.delete();
      m_active = 0; m_peak = 0; m_underrun = 0; m_ready_en = 0;
      m_tick = 0; m_next = 0;
      rx_cnt = 0; prev_rp = 0; prev_busy = 0;
    end else begin
      rdy_pre    = m_ready_en && (mq.size() < DEPTH);
      m_underrun = 0;
      if (sample_en) begin
        if (prev_rp) begin
          caps.push_back(rx_cnt);
          rx_cnt = 0;
        end else begin
          rx_cnt++;
        end
        if (!m_active) begin
          m_peak = (mq.size() != 0);
          if (m_peak) begin
            n        = mq.pop_front();
            m_active = 1;
            m_next   = m_tick + n + 1;
          end
        end else if (m_tick == m_next) begin
          m_peak = 1;
          if (mq.size() != 0) begin
            n      = mq.pop_front();
            m_next = m_tick + n + 1;
          end else begin
            m_underrun = 1;
            m_active   = 0;
          end
        end else begin
          m_peak = 0;
        end
        m_tick++;
      end
      if (rr_bus.rr_valid && rdy_pre) mq.push_back(int'(rr_bus.rr_in));
      m_ready_en = 1;

      if (sample_en) rp_hist.push_back(r_peak);
      if (sample_en && r_peak) begin
        peak_cnt++;
        peak_cyc.push_back(cyc);
      end
      if (underrun) begin
        ur_seen     = 1;
        ur_peak_idx = peak_cnt;
        ur_cyc      = cyc;
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      prev_rp   = r_peak;
    end
    check("r_peak", 64'(r_peak), 64'(m_peak));
    check("busy", 64'(busy), 64'(m_active));
    check("underrun", 64'(underrun), 64'(m_underrun));
    check("fifo_level", 64'(fifo_level), 64'(mq.size()));
    check("rr_ready", 64'(rr_bus.rr_ready), 64'(m_ready_en && (mq.size() < DEPTH)));
  end

  // Stimulus: everything advances one negedge at a time.
  int se_per = 0;
  int div    = 0;

  task automatic step_se(input bit se);
    sample_en = se;
    div++;
    @(negedge clk);
  endtask

  task automatic step();
    bit se;
    se = (se_per != 0) && ((div % se_per) == 0);
    step_se(se);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic push(input int v);
    bit acc;
    acc = 0;
    rr_bus.rr_in    = RR_W'(v);
    rr_bus.rr_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = rr_bus.rr_ready;
      step();
    end
    rr_bus.rr_valid = 1'b0;
    if (!acc) timeout_fail("push_accept");
  endtask

  task automatic run_until_ur(input int budget);
    for (int i = 0; i < budget && !ur_seen; i++) step();
    if (!ur_seen) timeout_fail("underrun_wait");
  endtask

  task automatic clear_traces();
    caps.delete(); peak_cyc.delete(); rp_hist.delete();
    peak_cnt = 0; ur_seen = 0; ur_peak_idx = -1; ur_cyc = -1; busy_fall_cyc = -2;
  endtask

  task automatic do_reset();
    se_per = 0;
    div    = 0;
    rr_bus.rr_valid = 1'b0;
    rst = 1'b1;
    step_se(0);
    step_se(0);
    clear_traces();
    rst = 1'b0;
    div = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pat[6] = '{1, 1, 0, 1, 1, 0};
    int first;
    rst = 1'b1;
    sample_en = 1'b0;
    rr_bus.rr_in = '0;
    rr_bus.rr_valid = 1'b0;
    do_reset();

    // Loopback, sample tick every 4 clk.
    se_per = 4;
    push(80); push(120); push(95);
    run_until_ur(2000);
    steps(10);
    check("lb_caps_count", 64'(caps.size()), 64'd4);
    if (caps.size() == 4) begin
      check("lb_cap1", 64'(caps[1]), 64'd80);
      check("lb_cap2", 64'(caps[2]), 64'd120);
      check("lb_cap3", 64'(caps[3]), 64'd95);
    end
    check("lb_peaks", 64'(peak_cnt), 64'd4);
    check("lb_ur_on_peak", 64'(ur_peak_idx), 64'd4);
    check("lb_busy_fall", 64'(busy_fall_cyc), 64'(ur_cyc));

    // Edge values 0, 1, 0.
    do_reset();
    se_per = 2;
    push(0); push(1); push(0);
    run_until_ur(200);
    steps(8);
    first = -1;
    for (int i = rp_hist.size() - 1; i >= 0; i--) if (rp_hist[i]) first = i;
    check("edge_first_peak_found", 64'(first >= 0), 64'd1);
    if (first >= 0 && first + 6 <= rp_hist.size())
      for (int i = 0; i < 6; i++) check("edge_pattern", 64'(rp_hist[first + i]), 64'(pat[i]));
    check("edge_caps_count", 64'(caps.size()), 64'd4);
    if (caps.size() == 4) begin
      check("edge_cap1", 64'(caps[1]), 64'd0);
      check("edge_cap2", 64'(caps[2]), 64'd1);
      check("edge_cap3", 64'(caps[3]), 64'd0);
    end

    // Backpressure with the tick held off.
    do_reset();
    push(3); push(2); push(2); push(2);
    check("bp_ready_full", 64'(rr_bus.rr_ready), 64'd0);
    check("bp_level_full", 64'(fifo_level), 64'd4);
    rr_bus.rr_in = 16'd9;
    rr_bus.rr_valid = 1'b1;
    step_se(1);
    check("bp_anchor", 64'(r_peak), 64'd1);
    check("bp_level_after_pop", 64'(fifo_level), 64'd3);
    check("bp_ready_after_pop", 64'(rr_bus.rr_ready), 64'd1);
    step_se(0);
    rr_bus.rr_valid = 1'b0;
    check("bp_fifth_accepted", 64'(fifo_level), 64'd4);

    // Push on the same clk as the final fire.
    do_reset();
    push(2);
    step_se(1); step_se(1); step_se(1);
    rr_bus.rr_in = 16'd3;
    rr_bus.rr_valid = 1'b1;
    step_se(1);
    rr_bus.rr_valid = 1'b0;
    check("sim_underrun", 64'(underrun), 64'd1);
    check("sim_idle", 64'(busy), 64'd0);
    check("sim_level", 64'(fifo_level), 64'd1);
    step_se(1);
    check("sim_anchor", 64'(r_peak), 64'd1);
    check("sim_anchor_busy", 64'(busy), 64'd1);
    // Push and pop on the same clk.
    rr_bus.rr_in = 16'd4;
    rr_bus.rr_valid = 1'b1;
    step_se(0);
    rr_bus.rr_valid = 1'b0;
    step_se(1); step_se(1); step_se(1);
    rr_bus.rr_in = 16'd5;
    rr_bus.rr_valid = 1'b1;
    step_se(1);
    rr_bus.rr_valid = 1'b0;
    check("pp_level", 64'(fifo_level), 64'd1);
    check("pp_fire", 64'(r_peak), 64'd1);

    // Reset mid-interval.
    do_reset();
    push(40); push(7);
    step_se(1);
    check("rst_pre_peak", 64'(r_peak), 64'd1);
    check("rst_pre_level", 64'(fifo_level), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_r_peak", 64'(r_peak), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ready", 64'(rr_bus.rr_ready), 64'd0);
    step_se(0);
    step_se(0);
    clear_traces();
    rst = 1'b0;
    div = 0;
    se_per = 1;
    steps(30);
    check("rst_quiet_peaks", 64'(peak_cnt), 64'd0);
    push(6);
    steps(2);
    check("rst_new_anchor", 64'(peak_cnt), 64'd1);

    // Continuous tick.
    do_reset();
    se_per = 1;
    push(3); push(2);
    run_until_ur(100);
    steps(3);
    check("ct_peaks", 64'(peak_cyc.size()), 64'd3);
    if (peak_cyc.size() == 3) begin
      check("ct_off1", 64'(peak_cyc[1] - peak_cyc[0]), 64'd4);
      check("ct_off2", 64'(peak_cyc[2] - peak_cyc[0]), 64'd7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
